// File: rtl/data_mem_arbiter_if.sv
// rtl/data_mem_arbiter_if.sv - requester and byte-memory bus bundle for data_mem_arbiter
interface data_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_DW     = 8
);
  logic                    req0;
  logic                    req1;
  logic                    we0;
  logic                    we1;
  logic [ADDR_WIDTH-1:0]   addr0;
  logic [ADDR_WIDTH-1:0]   addr1;
  logic [4*MEM_DW-1:0]     wdata0;
  logic [4*MEM_DW-1:0]     wdata1;
  logic                    done0;
  logic                    done1;
  logic                    err0;
  logic                    err1;
  logic [4*MEM_DW-1:0]     rdata;
  logic                    busy;
  logic                    mem_write;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [MEM_DW-1:0]       mem_wdata;
  logic [MEM_DW-1:0]       mem_rdata;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output done0, done1, err0, err1, rdata, busy, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  done0, done1, err0, err1, rdata, busy, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - round-robin word access for two requesters over a byte-wide memory; ARB_ALIGN_CHECK_EN enables misalignment reject
module data_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_DW     = 8
) (
  input logic               clk,
  input logic               rst,
  data_mem_arbiter_if.slave bus
);
  localparam int WORD_W = 4 * MEM_DW;

  typedef enum logic [1:0] {IDLE, XFER, DONE} stateT;

  stateT                 state;
  stateT                 stateNext;
  logic [1:0]            k;
  logic                  weLat;
  logic [ADDR_WIDTH-1:0] addrLat;
  logic [WORD_W-1:0]     wdataLat;
  logic [WORD_W-1:0]     rdataReg;
  logic                  grantIdx;
  logic                  lastGrant;
  logic                  anyReq;
  logic                  winner;
  logic [ADDR_WIDTH-1:0] winAddr;
  logic                  misaligned;
  logic                  errFlag;
  logic [MEM_DW-1:0]     laneW;

  assign anyReq  = bus.req0 | bus.req1;
  // With both asking, the requester that did not win last time gets the grant
  assign winner  = (bus.req0 && bus.req1) ? ~lastGrant : bus.req1;
  assign winAddr = winner ? bus.addr1 : bus.addr0;
  assign bus.rdata = rdataReg;

`ifdef ARB_ALIGN_CHECK_EN
  assign misaligned = (winAddr[1:0] != 2'b00);

  // Remember whether the current grant was rejected for misalignment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      errFlag <= 1'b0;
    end else if (state == IDLE && anyReq) begin
      errFlag <= misaligned;
    end
  end
`else
  assign misaligned = 1'b0;
  assign errFlag    = 1'b0;
`endif

  // Select the little-endian store byte for the current beat
  always_comb begin
    laneW = '0;
    for (int i = 0; i < 4; i++) begin
      if (k == 2'(i)) laneW = wdataLat[i*MEM_DW +: MEM_DW];
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  // Next state and bus outputs; everything idles at zero outside its own state
  always_comb begin
    stateNext     = state;
    bus.busy      = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.done0     = 1'b0;
    bus.done1     = 1'b0;
    bus.err0      = 1'b0;
    bus.err1      = 1'b0;
    case (state)
      IDLE: begin
        if (anyReq) stateNext = misaligned ? DONE : XFER;
      end
      XFER: begin
        bus.busy     = 1'b1;
        bus.mem_addr = addrLat + ADDR_WIDTH'(k);
        if (weLat) begin
          bus.mem_write = 1'b1;
          bus.mem_wdata = laneW;
        end
        if (k == 2'd3) stateNext = DONE;
      end
      DONE: begin
        bus.busy  = 1'b1;
        stateNext = IDLE;
        if (errFlag) begin
          bus.err0 = ~grantIdx;
          bus.err1 = grantIdx;
        end else begin
          bus.done0 = ~grantIdx;
          bus.done1 = grantIdx;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Latch the winning request, step the beat counter and gather load bytes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k         <= '0;
      weLat     <= 1'b0;
      addrLat   <= '0;
      wdataLat  <= '0;
      rdataReg  <= '0;
      grantIdx  <= 1'b0;
      lastGrant <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (anyReq) begin
            weLat     <= winner ? bus.we1 : bus.we0;
            addrLat   <= winAddr;
            wdataLat  <= winner ? bus.wdata1 : bus.wdata0;
            grantIdx  <= winner;
            lastGrant <= winner;
            k         <= '0;
          end
        end
        XFER: begin
          k <= k + 2'd1;
          if (!weLat) begin
            for (int i = 0; i < 4; i++) begin
              if (k == 2'(i)) rdataReg[i*MEM_DW +: MEM_DW] <= bus.mem_rdata;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - randomized self-checking bench for data_mem_arbiter against a byte-array memory model
module tb_data_mem_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_mem_arbiter_if bus ();

  data_mem_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  bit   [7:0]  tbMem  [256];
  bit   [7:0]  refMem [256];
  logic [31:0] expRdata;
  logic [31:0] wrAddrQ [$];
  logic [7:0]  wrDataQ [$];

  always_comb bus.mem_rdata = tbMem[bus.mem_addr[7:0]];

  always @(posedge clk) begin
    if (bus.mem_write) tbMem[bus.mem_addr[7:0]] <= bus.mem_wdata;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void modelStore(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] ai;
    for (int i = 0; i < 4; i++) begin
      ai = a + 32'(i);
      refMem[ai[7:0]] = d[8*i +: 8];
    end
  endfunction

  function automatic logic [31:0] modelLoad(input logic [31:0] a);
    logic [31:0] ai;
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < 4; i++) begin
      ai = a + 32'(i);
      w[8*i +: 8] = refMem[ai[7:0]];
    end
    return w;
  endfunction

  task automatic setPort(input bit p, input bit r, input bit we, input logic [31:0] a, input logic [31:0] d);
    if (p) begin
      bus.req1 = r; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
    end else begin
      bus.req0 = r; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
    end
  endtask

  task automatic applyReset();
    rst = 1'b1;
    setPort(1'b0, 1'b0, 1'b0, '0, '0);
    setPort(1'b1, 1'b0, 1'b0, '0, '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    expRdata = '0;
  endtask

  task automatic doTxn(input bit p, input bit we, input logic [31:0] a, input logic [31:0] d, input bit dropEarly,
                       output int doneC, output int errC, output int busyC, output int otherC,
                       output logic [31:0] rdAt);
    wrAddrQ.delete();
    wrDataQ.delete();
    doneC = 0; errC = 0; busyC = 0; otherC = 0; rdAt = 'x;
    @(posedge clk);
    #1 setPort(p, 1'b1, we, a, d);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (bus.busy) busyC++;
      if (bus.mem_write) begin
        wrAddrQ.push_back(bus.mem_addr);
        wrDataQ.push_back(bus.mem_wdata);
      end
      if (p ? bus.done1 : bus.done0) doneC = c;
      if (p ? bus.err1 : bus.err0) errC = c;
      if (p ? (bus.done0 | bus.err0) : (bus.done1 | bus.err1)) otherC++;
      if (doneC != 0 || errC != 0) begin
        rdAt = bus.rdata;
        break;
      end
      if (c == 2) setPort(p, !dropEarly, we, $urandom, $urandom);
    end
    @(posedge clk);
    #1 setPort(p, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    setPort(1'b1, 1'b0, 1'b0, '0, '0);
    setPort(1'b0, 1'b1, 1'b1, 32'h10, 32'h12345678);
    expRdata = '0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.mem_write !== 1'b0 || bus.done0 !== 1'b0 || bus.done1 !== 1'b0 ||
        bus.err0 !== 1'b0 || bus.err1 !== 1'b0 || bus.rdata !== 32'h0 || bus.mem_addr !== 32'h0 ||
        bus.mem_wdata !== 8'h0) begin
      failures++;
      $display("FAIL reset_outputs busy=%b wr=%b d=%b%b e=%b%b rdata=%h addr=%h wdata=%h required all zero",
               bus.busy, bus.mem_write, bus.done0, bus.done1, bus.err0, bus.err1, bus.rdata, bus.mem_addr, bus.mem_wdata);
    end
    setPort(1'b0, 1'b0, 1'b0, '0, '0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle busy=%b required 0", bus.busy);
    end
  endtask

  task automatic test_store_load();
    int dc, ec, bc, oc;
    logic [31:0] rd;
    bit bad;
    doTxn(1'b0, 1'b1, 32'h10, 32'hDDCCBBAA, 1'b0, dc, ec, bc, oc, rd);
    modelStore(32'h10, 32'hDDCCBBAA);
    checks++;
    if (dc !== 6 || oc !== 0 || ec !== 0) begin
      failures++;
      $display("FAIL store_done cycle=%0d other=%0d err=%0d required 6/0/0", dc, oc, ec);
    end
    bad = (wrAddrQ.size() != 4);
    if (!bad) for (int i = 0; i < 4; i++)
      if (wrAddrQ[i] !== 32'h10 + 32'(i) || wrDataQ[i] !== 8'hAA + 8'(17 * i)) bad = 1'b1;
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL store_beats got %0d beats required 4 at 10..13 bytes AA,BB,CC,DD", wrAddrQ.size());
    end
    checks++;
    if (rd !== expRdata) begin
      failures++;
      $display("FAIL store_rdata_hold got=%h required=%h", rd, expRdata);
    end
    @(negedge clk);
    checks++;
    if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 8'h0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_bus addr=%h wdata=%h busy=%b required 0/0/0", bus.mem_addr, bus.mem_wdata, bus.busy);
    end
    doTxn(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, dc, ec, bc, oc, rd);
    expRdata = modelLoad(32'h10);
    checks++;
    if (dc !== 6 || rd !== 32'hDDCCBBAA || wrAddrQ.size() != 0) begin
      failures++;
      $display("FAIL load_word cycle=%0d rdata=%h writes=%0d required 6/DDCCBBAA/0", dc, rd, wrAddrQ.size());
    end
  endtask

  task automatic test_random();
    int dc, ec, bc, oc;
    logic [31:0] rd, a, d, exp;
    bit p, we, drop, bad;
    for (int it = 0; it < 24; it++) begin
      p = 1'($urandom);
      we = 1'($urandom);
      drop = ($urandom_range(0, 3) == 0);
      a = 32'($urandom_range(0, 62)) << 2;
      d = $urandom;
      doTxn(p, we, a, d, drop, dc, ec, bc, oc, rd);
      checks++;
      if (dc !== 6) begin
        failures++;
        $display("FAIL rand_latency it=%0d got=%0d required=6", it, dc);
      end
      checks++;
      if (ec !== 0 || oc !== 0 || bc !== 5) begin
        failures++;
        $display("FAIL rand_pulses it=%0d err=%0d other=%0d busy=%0d required 0/0/5", it, ec, oc, bc);
      end
      if (we) begin
        modelStore(a, d);
        bad = (wrAddrQ.size() != 4);
        if (!bad) for (int i = 0; i < 4; i++)
          if (wrAddrQ[i] !== a + 32'(i) || wrDataQ[i] !== d[8*i +: 8]) bad = 1'b1;
        checks++;
        if (bad || rd !== expRdata) begin
          failures++;
          $display("FAIL rand_store it=%0d beats=%0d rdata=%h required 4 beats of %h at %h, rdata=%h",
                   it, wrAddrQ.size(), rd, d, a, expRdata);
        end
      end else begin
        exp = modelLoad(a);
        checks++;
        if (rd !== exp || wrAddrQ.size() != 0) begin
          failures++;
          $display("FAIL rand_load it=%0d addr=%h got=%h writes=%0d required=%h writes=0", it, a, rd, wrAddrQ.size(), exp);
        end
        expRdata = exp;
      end
    end
  endtask

  task automatic test_round_robin();
    logic [31:0] d, rdFirst, m0, m1, e0, e1;
    int ptr, w, wr;
    bit seen;
    applyReset();
    d = $urandom;
    @(posedge clk);
    #1;
    setPort(1'b0, 1'b1, 1'b1, 32'h40, d);
    setPort(1'b1, 1'b1, 1'b0, 32'h40, 32'h0);
    m0 = '0; m1 = '0; wr = 0; seen = 1'b0; rdFirst = '0;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      if (bus.done0) m0[c] = 1'b1;
      if (bus.done1) begin
        m1[c] = 1'b1;
        if (!seen) rdFirst = bus.rdata;
        seen = 1'b1;
      end
      if (bus.mem_write) wr++;
    end
    @(posedge clk);
    #1;
    setPort(1'b0, 1'b0, 1'b0, '0, '0);
    setPort(1'b1, 1'b0, 1'b0, '0, '0);
    e0 = '0; e1 = '0; ptr = 0;
    for (int g = 0; g < 4; g++) begin
      w = ptr;
      if (w == 0) e0[6*(g+1)] = 1'b1;
      else        e1[6*(g+1)] = 1'b1;
      ptr = 1 - w;
    end
    modelStore(32'h40, d);
    expRdata = modelLoad(32'h40);
    checks++;
    if (m0 !== e0 || m1 !== e1) begin
      failures++;
      $display("FAIL rr_grants done0=%h done1=%h required %h %h", m0, m1, e0, e1);
    end
    checks++;
    if (wr !== 8 || rdFirst !== expRdata) begin
      failures++;
      $display("FAIL rr_data writes=%0d rdata=%h required 8/%h", wr, rdFirst, expRdata);
    end
  endtask

  task automatic test_wrap();
    int dc, ec, bc, oc;
    logic [31:0] rd, d, exp;
    bit bad;
    d = $urandom;
    doTxn(1'b1, 1'b1, 32'hFFFFFFFE, d, 1'b0, dc, ec, bc, oc, rd);
    modelStore(32'hFFFFFFFE, d);
    bad = (wrAddrQ.size() != 4);
    if (!bad) bad = (wrAddrQ[0] !== 32'hFFFFFFFE || wrAddrQ[1] !== 32'hFFFFFFFF ||
                     wrAddrQ[2] !== 32'h0 || wrAddrQ[3] !== 32'h1 || wrDataQ[3] !== d[31:24]);
    checks++;
    if (bad || dc !== 6) begin
      failures++;
      $display("FAIL wrap_addr beats=%0d done=%0d required FFFFFFFE,FFFFFFFF,0,1 done=6", wrAddrQ.size(), dc);
    end
    doTxn(1'b0, 1'b0, 32'hFFFFFFFE, 32'h0, 1'b0, dc, ec, bc, oc, rd);
    exp = modelLoad(32'hFFFFFFFE);
    expRdata = exp;
    checks++;
    if (rd !== exp) begin
      failures++;
      $display("FAIL wrap_load got=%h required=%h", rd, exp);
    end
  endtask

  task automatic test_reset_mid();
    int dc, ec, bc, oc, stray;
    logic [31:0] rd, d, exp;
    d = $urandom;
    doTxn(1'b0, 1'b1, 32'h60, ~d, 1'b0, dc, ec, bc, oc, rd);
    modelStore(32'h60, ~d);
    @(posedge clk);
    #1 setPort(1'b0, 1'b1, 1'b1, 32'h60, d);
    for (int c = 1; c <= 4; c++) @(negedge clk);
    checks++;
    if (bus.mem_write !== 1'b1 || bus.mem_addr !== 32'h62) begin
      failures++;
      $display("FAIL mid_beat2 wr=%b addr=%h required 1/00000062", bus.mem_write, bus.mem_addr);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.mem_write !== 1'b0 || bus.busy !== 1'b0 || bus.mem_addr !== 32'h0 ||
        bus.mem_wdata !== 8'h0 || bus.rdata !== 32'h0 || bus.done0 !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset wr=%b busy=%b addr=%h wdata=%h rdata=%h done0=%b required all zero",
               bus.mem_write, bus.busy, bus.mem_addr, bus.mem_wdata, bus.rdata, bus.done0);
    end
    setPort(1'b0, 1'b0, 1'b0, '0, '0);
    @(posedge clk);
    #1 rst = 1'b0;
    expRdata = '0;
    stray = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.done0 || bus.done1 || bus.busy) stray++;
    end
    checks++;
    if (stray !== 0) begin
      failures++;
      $display("FAIL mid_abandon active_cycles=%0d required=0", stray);
    end
    refMem[8'h60] = d[7:0];
    refMem[8'h61] = d[15:8];
    doTxn(1'b1, 1'b0, 32'h60, 32'h0, 1'b0, dc, ec, bc, oc, rd);
    exp = modelLoad(32'h60);
    expRdata = exp;
    checks++;
    if (rd !== exp) begin
      failures++;
      $display("FAIL mid_partial got=%h required=%h", rd, exp);
    end
  endtask

  task automatic test_align();
    int dc, ec, bc, oc, d0c, d1c;
    logic [31:0] rd, exp;
`ifdef ARB_ALIGN_CHECK_EN
    doTxn(1'b0, 1'b0, 32'h21, 32'h0, 1'b0, dc, ec, bc, oc, rd);
    checks++;
    if (ec !== 2 || dc !== 0 || wrAddrQ.size() != 0 || rd !== expRdata || bc !== 1) begin
      failures++;
      $display("FAIL align_load err=%0d done=%0d writes=%0d rdata=%h busy=%0d required 2/0/0/%h/1",
               ec, dc, wrAddrQ.size(), rd, expRdata, bc);
    end
    doTxn(1'b0, 1'b1, 32'h23, $urandom, 1'b0, dc, ec, bc, oc, rd);
    checks++;
    if (ec !== 2 || wrAddrQ.size() != 0) begin
      failures++;
      $display("FAIL align_store err=%0d writes=%0d required 2/0", ec, wrAddrQ.size());
    end
`else
    doTxn(1'b0, 1'b0, 32'h21, 32'h0, 1'b0, dc, ec, bc, oc, rd);
    exp = modelLoad(32'h21);
    expRdata = exp;
    checks++;
    if (dc !== 6 || ec !== 0 || rd !== exp) begin
      failures++;
      $display("FAIL unaligned_load done=%0d err=%0d rdata=%h required 6/0/%h", dc, ec, rd, exp);
    end
`endif
    @(posedge clk);
    #1;
    setPort(1'b0, 1'b1, 1'b0, 32'h30, 32'h0);
    setPort(1'b1, 1'b1, 1'b0, 32'h30, 32'h0);
    d0c = 0; d1c = 0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (bus.done1 && d1c == 0) begin d1c = c; bus.req1 = 1'b0; end
      if (bus.done0 && d0c == 0) begin d0c = c; bus.req0 = 1'b0; end
      if (d0c != 0 && d1c != 0) break;
    end
    @(posedge clk);
    #1;
    setPort(1'b0, 1'b0, 1'b0, '0, '0);
    setPort(1'b1, 1'b0, 1'b0, '0, '0);
    expRdata = modelLoad(32'h30);
    checks++;
    if (d1c !== 6 || d0c !== 12) begin
      failures++;
      $display("FAIL pointer_after_p0 done1=%0d done0=%0d required 6/12", d1c, d0c);
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_random();
    test_round_robin();
    test_wrap();
    test_reset_mid();
    test_align();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte-address width of requesters and memory.
REQ-002 SHALL have parameter MEM_DW, default 8, fixed byte-wide memory data width; the requester word is 4*MEM_DW bits.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-005 SHALL have ports req0/req1, input, 1 each, meaning access request from requester 0/1, held until its done.
REQ-006 SHALL have ports we0/we1, input, 1 each, meaning 1 = word store, 0 = word load.
REQ-007 SHALL have ports addr0/addr1, input, ADDR_WIDTH each, meaning word start byte address.
REQ-008 SHALL have ports wdata0/wdata1, input, 4*MEM_DW each, meaning store data.
REQ-009 SHALL have ports done0/done1, output, 1 each, meaning one-cycle completion pulse.
REQ-010 SHALL have ports err0/err1, output, 1 each, meaning one-cycle misalignment-reject pulse.
REQ-011 SHALL have port rdata, output, 4*MEM_DW, meaning load result, valid in the done cycle.
REQ-012 SHALL have port busy, output, 1, meaning a transfer is in progress.
REQ-013 SHALL have port mem_write, output, 1, meaning the memory write strobe.
REQ-014 SHALL have port mem_addr, output, ADDR_WIDTH, meaning the memory byte address.
REQ-015 SHALL have port mem_wdata, output, MEM_DW, meaning the memory write byte.
REQ-016 SHALL have port mem_rdata, input, MEM_DW, meaning the combinational memory read byte.

Function
REQ-017 SHALL implement an FSM with states IDLE, XFER and DONE.
REQ-018 In IDLE with any req high, SHALL latch the winner's we, addr and wdata, clear beat counter k, and enter XFER next cycle.
REQ-019 Arbitration SHALL be round-robin: with both requests high, grant the requester not granted last; with one request high, grant it.
REQ-020 The round-robin pointer SHALL update only on grant.
REQ-021 XFER SHALL run exactly 4 cycles, k = 0..3, driving mem_addr = latched addr + k, with the sum modulo 2^ADDR_WIDTH (wrap from all-ones to 0 permitted).
REQ-022 Byte order SHALL be little-endian: beat k uses lane bits [8k+7:8k] of wdata/rdata (generalised to MEM_DW).
REQ-023 For a store, SHALL drive mem_write=1 and mem_wdata=lane k in each XFER cycle.
REQ-024 Outside XFER-store cycles, mem_write SHALL be 0, including in IDLE and DONE.
REQ-025 For a load, SHALL capture mem_rdata into rdata lane k at the end of each XFER cycle.
REQ-026 For a store, rdata SHALL hold its previous value.
REQ-027 DONE SHALL last 1 cycle, pulse done of the granted requester only, then return to IDLE.
REQ-028 Request-to-done latency SHALL be 6 cycles (IDLE sample, 4 XFER, DONE).
REQ-029 A new grant is possible in the cycle after DONE.
REQ-030 Deassertion of req or changes to addr/wdata during XFER SHALL not affect the latched transfer, which completes.
REQ-031 busy SHALL be 1 in XFER and DONE, 0 in IDLE.
REQ-032 When no transfer is active, mem_addr SHALL be 0 and mem_wdata SHALL be 0.

Reset
REQ-033 Asserting rst at any time SHALL immediately force IDLE, mem_write=0, all done/err=0, busy=0, rdata=0, mem_addr=0, mem_wdata=0, k=0, and the round-robin pointer to favour requester 0.
REQ-034 A transfer interrupted by reset SHALL be abandoned with no done pulse; bytes already written remain written.

Configuration
REQ-035 Macro ARB_ALIGN_CHECK_EN, when defined: a granted request with addr[1:0]!=0 SHALL skip XFER, pulse that requester's err for one cycle in place of DONE, issue no memory strobe, and still advance the pointer.
REQ-036 When ARB_ALIGN_CHECK_EN is undefined: err0/err1 SHALL be tied 0, and unaligned addresses SHALL be transferred byte-wise per REQ-021.

Verification
REQ-037 Store req0 addr=0x10 wdata=0xDDCCBBAA -> mem_write 4 cycles at 0x10..0x13 with bytes AA,BB,CC,DD; done0 in cycle 6.
REQ-038 Load req1 addr=0x10 after REQ-037 -> rdata=0xDDCCBBAA with done1; mem_write stays 0.
REQ-039 req0 and req1 both held continuously from reset -> grants alternate 0,1,0,1; done pulses every 6 cycles.
REQ-040 Store addr=0xFFFFFFFE -> mem_addr sequence FFFFFFFE, FFFFFFFF, 0, 1 (without ARB_ALIGN_CHECK_EN).
REQ-041 rst asserted during XFER beat 2 of a store -> mem_write drops immediately; no done; IDLE next; only beats 0-1 written.
REQ-042 With ARB_ALIGN_CHECK_EN, load addr=0x21 -> err pulse 2 cycles after request, no mem_write, rdata unchanged.
